// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction fetch controller. Walks a PC through instruction
//               memory with a one-entry ready/valid output stage, supports
//               redirects, and traps on misaligned or out-of-range PCs.
//               Optional macro IMEM_FETCH_PERF_CNT_EN adds a fetch_count
//               output counting transferred beats.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          IMEM_DEPTH_BYTES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fault_addr,
`ifdef IMEM_FETCH_PERF_CNT_EN
    input  logic        fault_clear,
    output logic [31:0] fetch_count
`else
    input  logic        fault_clear
`endif
);

    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_fetch    = 2'd1;
    localparam logic [1:0]  c_fault    = 2'd2;
    localparam logic [31:0] c_max_addr = 32'(IMEM_DEPTH_BYTES - 4);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_fault;
    logic [31:0] r_fault_addr;

    logic        w_slot_free;
    logic        w_pc_legal;

    // The output register can take a new word when empty or being drained.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_pc_legal  = (r_pc[1:0] == 2'b00) && (r_pc <= c_max_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_pc         <= RESET_PC;
            r_out_valid  <= 1'b0;
            r_out_instr  <= 32'd0;
            r_out_pc     <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (run) begin
                        r_state <= c_fetch;
                    end
                end
                c_fetch: begin
                    if (redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= redirect_pc;
                    end else if (w_slot_free) begin
                        if (w_pc_legal) begin
                            r_out_instr <= imem_rdata;
                            r_out_pc    <= r_pc;
                            r_out_valid <= 1'b1;
                            r_pc        <= r_pc + 32'd4;
                        end else begin
                            // Trap only once any pending beat has left, so
                            // no accepted word is lost.
                            r_out_valid  <= 1'b0;
                            r_fault      <= 1'b1;
                            r_fault_addr <= r_pc;
                            r_state      <= c_fault;
                        end
                    end
                end
                c_fault: begin
                    r_out_valid <= 1'b0;
                    if (fault_clear) begin
                        r_pc    <= RESET_PC;
                        r_fault <= 1'b0;
                        r_state <= c_fetch;
                    end
                end
                default: begin
                    r_state     <= c_idle;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
        end else if (r_out_valid && out_ready) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    assign imem_addr  = r_pc;
    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_pc     = r_out_pc;
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Scoreboard bench for imem_fetch_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fault;
    logic [31:0] fault_addr;
    logic        fault_clear = 1'b0;
`ifdef IMEM_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    imem_fetch_ctrl #(
        .RESET_PC         (32'h0000_0000),
        .IMEM_DEPTH_BYTES (200)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_addr     (fault_addr),
`ifdef IMEM_FETCH_PERF_CNT_EN
        .fault_clear    (fault_clear),
        .fetch_count    (fetch_count)
`else
        .fault_clear    (fault_clear)
`endif
    );

    always #5 clk = ~clk;

    // Word k lives at byte address 4k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + (a >> 2);
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [31:0] first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    // Monitor: a beat transfers at the next edge when valid and ready are high now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("beat_pc", out_pc, e);
                check("beat_instr", out_instr, mem_word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int vcnt;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        tick(); tick();
        check("idle_hold_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold_pc", imem_addr, 32'd0);

        // Full sweep to the end of memory, run dropped after start
        push_range(32'd0, 50);
        run = 1'b1; out_ready = 1'b1;
        tick();
        run = 1'b0;
        n = 0; vcnt = 0;
        while (!fault && n < 80) begin
            tick();
            if (out_valid) vcnt++;
            n++;
        end
        check("sweep_fault", {31'd0, fault}, 32'd1);
        check("sweep_fault_addr", fault_addr, 32'd200);
        check("sweep_consecutive_beats", 32'(vcnt), 32'd50);
        check("sweep_valid_after_fault", {31'd0, out_valid}, 32'd0);
        check("sweep_queue_drained", 32'(exp_q.size()), 32'd0);

        // Redirect ignored in FAULT, then clear beats a simultaneous redirect
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        tick();
        check("fault_redirect_ignored_pc", imem_addr, 32'd200);
        check("fault_hold_addr", fault_addr, 32'd200);
        check("fault_hold", {31'd0, fault}, 32'd1);
        push_range(32'd0, 2);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0; redirect_valid = 1'b0;
        check("clear_pc", imem_addr, 32'd0);
        check("clear_fault", {31'd0, fault}, 32'd0);

        // Stall three cycles at out_pc=8
        n = 0;
        while (!(out_valid && out_pc == 32'd8) && n < 10) begin tick(); n++; end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, 32'd8);
            check("stall_instr", out_instr, mem_word(32'd8));
            check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        push_range(32'd8, 3);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("stall_resume_queue", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect faults two cycles later with no beat
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd10;
        tick();
        redirect_valid = 1'b0;
        check("redir10_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir10_fault", {31'd0, fault}, 32'd1);
        check("redir10_fault_addr", fault_addr, 32'd10);
        check("redir10_no_beat", {31'd0, out_valid}, 32'd0);

        // Clear restarts at 0; then redirect to 40 while out_pc=8 pending
        push_range(32'd0, 2);
        out_ready = 1'b1; fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n = 0;
        while (!(out_valid && out_pc == 32'd8) && n < 10) begin tick(); n++; end
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd40;
        tick();
        redirect_valid = 1'b0;
        check("redir40_valid_drop", {31'd0, out_valid}, 32'd0);
        check("redir40_addr", imem_addr, 32'd40);
        push_range(32'd40, 2);
        out_ready = 1'b1;
        tick();
        check("redir40_first_pc", out_pc, 32'd40);
        tick(); tick();
        out_ready = 1'b0;
        check("redir40_queue", 32'(exp_q.size()), 32'd0);
`ifdef IMEM_FETCH_PERF_CNT_EN
        check("count_before_rst", fetch_count, 32'd59);
`endif

        // Reset mid-beat discards the pending word
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_pc", imem_addr, 32'd0);
        check("midrst_out_pc", out_pc, 32'd0);
`ifdef IMEM_FETCH_PERF_CNT_EN
        check("midrst_count", fetch_count, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);

        // Ten beats with two stall cycles and one redirect
        push_range(32'd0, 3);
        run = 1'b1; out_ready = 1'b1;
        tick();
        run = 1'b0;
        n = 0;
        while (!(out_valid && out_pc == 32'd8) && n < 10) begin tick(); n++; end
        out_ready = 1'b0;
        tick(); tick();
        check("cnt_stall_pc", out_pc, 32'd8);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'd100;
        tick();
        redirect_valid = 1'b0;
        push_range(32'd100, 7);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin tick(); n++; end
        out_ready = 1'b0;
        check("cnt_queue_drained", 32'(exp_q.size()), 32'd0);
        check("cnt_next_pc", out_pc, 32'd128);
`ifdef IMEM_FETCH_PERF_CNT_EN
        check("fetch_count_10", fetch_count, 32'd10);
`endif
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
